// File: rtl/zion_basic_circuit_lib_dat_unpack_if.sv
// Handshake bundle for the wide-to-narrow unpacker.
// The slave modport is the unpacker's view; the master modport is the view
// of whatever drives words in and consumes slices out.
interface zion_basic_circuit_lib_dat_unpack_if #(
    parameter int WIDTH_DATA_IN  = 64,
    parameter int WIDTH_DATA_OUT = 16
);
    localparam int WIDTH_ADDR = $clog2(WIDTH_DATA_IN / WIDTH_DATA_OUT);

    logic                      iVld;
    logic                      oRdy;
    logic [WIDTH_DATA_IN-1:0]  iDat;
    logic [WIDTH_ADDR-1:0]     iLen;
    logic                      oVld;
    logic                      iRdy;
    logic [WIDTH_DATA_OUT-1:0] oDat;
    logic [WIDTH_ADDR-1:0]     oAddr;
    logic                      oLast;

    modport slave (
        input  iVld, iDat, iLen, iRdy,
        output oRdy, oVld, oDat, oAddr, oLast
    );

    modport master (
        output iVld, iDat, iLen, iRdy,
        input  oRdy, oVld, oDat, oAddr, oLast
    );
endinterface

// File: rtl/zion_basic_circuit_lib_dat_unpack.sv
// Sequential wide-to-narrow unpacker: accepts one wide word per input
// handshake and presents it as 1..N narrow slices, one per output handshake.
// All slice outputs are registered, so nothing on the input side reaches
// oVld/oDat combinationally; only oRdy looks at the downstream iRdy so a new
// word can be taken in the same cycle the last slice leaves.
module zion_basic_circuit_lib_dat_unpack #(
    parameter int WIDTH_DATA_IN  = 64,
    parameter int WIDTH_DATA_OUT = 16,
    parameter int ADDR_TYPE      = 1
) (
    input  logic clk,
    input  logic rst_n,
    zion_basic_circuit_lib_dat_unpack_if.slave bus
);
    localparam int N          = WIDTH_DATA_IN / WIDTH_DATA_OUT;
    localparam int WIDTH_ADDR = $clog2(N);
    localparam logic [WIDTH_ADDR-1:0] LAST_IDX = WIDTH_ADDR'(N - 1);

    if ((WIDTH_DATA_OUT < 1) || (WIDTH_DATA_IN % WIDTH_DATA_OUT != 0) ||
        (N < 2) || (ADDR_TYPE < 0) || (ADDR_TYPE > 1)) begin : g_bad_params
        $error("zion_basic_circuit_lib_dat_unpack: illegal parameter combination");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                    state;
    logic [WIDTH_DATA_IN-1:0]  hold;
    logic [WIDTH_ADDR-1:0]     count;
    logic [WIDTH_ADDR-1:0]     len;
    logic                      out_vld;
    logic [WIDTH_DATA_OUT-1:0] out_dat;
    logic [WIDTH_ADDR-1:0]     out_addr;
    logic                      out_last;

    logic                      take;
    logic                      give;
    logic                      rdy;
    logic [WIDTH_ADDR-1:0]     len_clamped;
    logic [WIDTH_ADDR-1:0]     count_next;

    // Map a position in the emission order to the slice index in the word.
    function automatic logic [WIDTH_ADDR-1:0] slice_idx(input logic [WIDTH_ADDR-1:0] pos);
        if (ADDR_TYPE == 1) begin
            return pos;
        end
        return LAST_IDX - pos;
    endfunction

    // Extract one narrow slice from a wide word.
    function automatic logic [WIDTH_DATA_OUT-1:0] slice_of(input logic [WIDTH_DATA_IN-1:0] word,
                                                          input logic [WIDTH_ADDR-1:0]    idx);
        return word[int'(idx) * WIDTH_DATA_OUT +: WIDTH_DATA_OUT];
    endfunction

    // Handshake qualifiers; a new word may enter as the last slice drains.
    always_comb begin
        rdy         = (state == IDLE) | (out_vld & bus.iRdy & out_last);
        take        = bus.iVld & rdy;
        give        = out_vld & bus.iRdy;
        len_clamped = (bus.iLen > LAST_IDX) ? LAST_IDX : bus.iLen;
        count_next  = count + WIDTH_ADDR'(1);
    end

    // Unpacker FSM with registered slice outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold     <= '0;
            count    <= '0;
            len      <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_addr <= '0;
            out_last <= 1'b0;
        end else if (take) begin
            state    <= SEND;
            hold     <= bus.iDat;
            len      <= len_clamped;
            count    <= '0;
            out_vld  <= 1'b1;
            out_dat  <= slice_of(bus.iDat, slice_idx('0));
            out_addr <= slice_idx('0);
            out_last <= (len_clamped == '0);
        end else if (give) begin
            if (out_last) begin
                state   <= IDLE;
                out_vld <= 1'b0;
            end else begin
                count    <= count_next;
                out_dat  <= slice_of(hold, slice_idx(count_next));
                out_addr <= slice_idx(count_next);
                out_last <= (count_next == len);
            end
        end
    end

    assign bus.oRdy  = rdy;
    assign bus.oVld  = out_vld;
    assign bus.oDat  = out_dat;
    assign bus.oAddr = out_addr;
    assign bus.oLast = out_last;
endmodule

// File: tb/tb_zion_basic_circuit_lib_dat_unpack.sv
// Directed bench for the unpacker: LSB-first and MSB-first 64->16 instances
// plus a 48->16 instance for length clamping.
module tb_zion_basic_circuit_lib_dat_unpack;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    localparam logic [63:0] WORD_A = 64'h4444_3333_2222_1111;
    localparam logic [63:0] WORD_B = 64'h8888_7777_6666_5555;

    zion_basic_circuit_lib_dat_unpack_if #(.WIDTH_DATA_IN(64), .WIDTH_DATA_OUT(16)) b0 ();
    zion_basic_circuit_lib_dat_unpack_if #(.WIDTH_DATA_IN(64), .WIDTH_DATA_OUT(16)) b1 ();
    zion_basic_circuit_lib_dat_unpack_if #(.WIDTH_DATA_IN(48), .WIDTH_DATA_OUT(16)) b2 ();

    zion_basic_circuit_lib_dat_unpack #(.WIDTH_DATA_IN(64), .WIDTH_DATA_OUT(16), .ADDR_TYPE(1))
        u_lsb (.clk(clk), .rst_n(rst_n), .bus(b0));
    zion_basic_circuit_lib_dat_unpack #(.WIDTH_DATA_IN(64), .WIDTH_DATA_OUT(16), .ADDR_TYPE(0))
        u_msb (.clk(clk), .rst_n(rst_n), .bus(b1));
    zion_basic_circuit_lib_dat_unpack #(.WIDTH_DATA_IN(48), .WIDTH_DATA_OUT(16), .ADDR_TYPE(1))
        u_n3 (.clk(clk), .rst_n(rst_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        b0.iVld = 1'b0; b0.iDat = '0; b0.iLen = '0; b0.iRdy = 1'b1;
        b1.iVld = 1'b0; b1.iDat = '0; b1.iLen = '0; b1.iRdy = 1'b1;
        b2.iVld = 1'b0; b2.iDat = '0; b2.iLen = '0; b2.iRdy = 1'b1;
        cycle();
        cycle();
        tests++;
        if ({b0.oVld, b0.oDat, b0.oAddr, b0.oLast, b0.oRdy} !== {1'b0, 16'h0, 2'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset_lsb got vld=%b dat=%h addr=%0d last=%b rdy=%b want 0 0000 0 0 1",
                     b0.oVld, b0.oDat, b0.oAddr, b0.oLast, b0.oRdy);
        end
        tests++;
        if ({b1.oVld, b1.oDat, b1.oAddr, b1.oLast, b1.oRdy} !== {1'b0, 16'h0, 2'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL reset_msb got vld=%b dat=%h addr=%0d last=%b rdy=%b want 0 0000 0 0 1",
                     b1.oVld, b1.oDat, b1.oAddr, b1.oLast, b1.oRdy);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_lsb_first();
        logic [63:0] w;
        b0.iVld = 1'b1; b0.iDat = WORD_A; b0.iLen = 2'd3; b0.iRdy = 1'b1;
        cycle();
        b0.iVld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = WORD_A >> (16 * k);
            tests++;
            if ({b0.oVld, b0.oDat, b0.oAddr, b0.oLast} !== {1'b1, w[15:0], 2'(k), (k == 3)}) begin
                fails++;
                $display("[TB] FAIL lsb_slice%0d got vld=%b dat=%h addr=%0d last=%b want 1 %h %0d %b",
                         k, b0.oVld, b0.oDat, b0.oAddr, b0.oLast, w[15:0], k, (k == 3));
            end
            cycle();
        end
        tests++;
        if (b0.oVld !== 1'b0 || b0.oRdy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL lsb_idle got vld=%b rdy=%b want 0 1", b0.oVld, b0.oRdy);
        end
    endtask

    task automatic test_msb_first();
        logic [63:0] w;
        b1.iVld = 1'b1; b1.iDat = WORD_A; b1.iLen = 2'd3; b1.iRdy = 1'b1;
        cycle();
        b1.iVld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            w = WORD_A >> (16 * (3 - k));
            tests++;
            if ({b1.oVld, b1.oDat, b1.oAddr, b1.oLast} !== {1'b1, w[15:0], 2'(3 - k), (k == 3)}) begin
                fails++;
                $display("[TB] FAIL msb_slice%0d got vld=%b dat=%h addr=%0d last=%b want 1 %h %0d %b",
                         k, b1.oVld, b1.oDat, b1.oAddr, b1.oLast, w[15:0], 3 - k, (k == 3));
            end
            cycle();
        end
        tests++;
        if (b1.oVld !== 1'b0) begin
            fails++;
            $display("[TB] FAIL msb_idle got vld=%b want 0", b1.oVld);
        end
    endtask

    task automatic test_backpressure();
        b0.iVld = 1'b1; b0.iDat = WORD_A; b0.iLen = 2'd3; b0.iRdy = 1'b1;
        cycle();
        b0.iVld = 1'b0;
        cycle();
        b0.iRdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests++;
            if ({b0.oVld, b0.oDat, b0.oAddr, b0.oLast, b0.oRdy} !== {1'b1, 16'h2222, 2'd1, 1'b0, 1'b0}) begin
                fails++;
                $display("[TB] FAIL bp_hold%0d got vld=%b dat=%h addr=%0d last=%b rdy=%b want 1 2222 1 0 0",
                         k, b0.oVld, b0.oDat, b0.oAddr, b0.oLast, b0.oRdy);
            end
        end
        b0.iRdy = 1'b1;
        cycle();
        tests++;
        if ({b0.oVld, b0.oDat, b0.oAddr} !== {1'b1, 16'h3333, 2'd2}) begin
            fails++;
            $display("[TB] FAIL bp_resume got vld=%b dat=%h addr=%0d want 1 3333 2",
                     b0.oVld, b0.oDat, b0.oAddr);
        end
        cycle();
        cycle();
        tests++;
        if (b0.oVld !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_idle got vld=%b want 0", b0.oVld);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] w;
        b0.iVld = 1'b1; b0.iDat = WORD_A; b0.iLen = 2'd3; b0.iRdy = 1'b1;
        cycle();
        b0.iDat = WORD_B;
        for (int i = 0; i < 8; i++) begin
            w = ((i < 4) ? WORD_A : WORD_B) >> (16 * (i % 4));
            tests++;
            if ({b0.oVld, b0.oDat, b0.oAddr, b0.oLast} !== {1'b1, w[15:0], 2'(i % 4), (i % 4 == 3)}) begin
                fails++;
                $display("[TB] FAIL b2b_slice%0d got vld=%b dat=%h addr=%0d last=%b want 1 %h %0d %b",
                         i, b0.oVld, b0.oDat, b0.oAddr, b0.oLast, w[15:0], i % 4, (i % 4 == 3));
            end
            if (i == 3 || i == 1) begin
                tests++;
                if (b0.oRdy !== (i == 3)) begin
                    fails++;
                    $display("[TB] FAIL b2b_rdy%0d got %b want %b", i, b0.oRdy, (i == 3));
                end
            end
            if (i == 4) begin
                b0.iVld = 1'b0;
            end
            cycle();
        end
        tests++;
        if (b0.oVld !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_idle got vld=%b want 0", b0.oVld);
        end
    endtask

    task automatic test_len();
        b0.iVld = 1'b1; b0.iDat = WORD_A; b0.iLen = 2'd0; b0.iRdy = 1'b1;
        cycle();
        b0.iVld = 1'b0;
        tests++;
        if ({b0.oVld, b0.oDat, b0.oAddr, b0.oLast} !== {1'b1, 16'h1111, 2'd0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL len0_slice got vld=%b dat=%h addr=%0d last=%b want 1 1111 0 1",
                     b0.oVld, b0.oDat, b0.oAddr, b0.oLast);
        end
        cycle();
        tests++;
        if (b0.oVld !== 1'b0 || b0.oRdy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL len0_idle got vld=%b rdy=%b want 0 1", b0.oVld, b0.oRdy);
        end

        b2.iVld = 1'b1; b2.iDat = 48'h3333_2222_1111; b2.iLen = 2'd3; b2.iRdy = 1'b1;
        cycle();
        b2.iVld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({b2.oVld, b2.oDat, b2.oAddr, b2.oLast} !==
                {1'b1, 16'(16'h1111 * (k + 1)), 2'(k), (k == 2)}) begin
                fails++;
                $display("[TB] FAIL clamp_slice%0d got vld=%b dat=%h addr=%0d last=%b want 1 %h %0d %b",
                         k, b2.oVld, b2.oDat, b2.oAddr, b2.oLast, 16'(16'h1111 * (k + 1)), k, (k == 2));
            end
            cycle();
        end
        tests++;
        if (b2.oVld !== 1'b0) begin
            fails++;
            $display("[TB] FAIL clamp_idle got vld=%b want 0", b2.oVld);
        end
    endtask

    task automatic test_reset_mid_burst();
        b0.iVld = 1'b1; b0.iDat = WORD_A; b0.iLen = 2'd3; b0.iRdy = 1'b1;
        cycle();
        b0.iVld = 1'b0;
        cycle();
        tests++;
        if (b0.oDat !== 16'h2222) begin
            fails++;
            $display("[TB] FAIL mid_pre got dat=%h want 2222", b0.oDat);
        end
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({b0.oVld, b0.oDat, b0.oAddr, b0.oLast, b0.oRdy} !== {1'b0, 16'h0, 2'd0, 1'b0, 1'b1}) begin
            fails++;
            $display("[TB] FAIL mid_reset got vld=%b dat=%h addr=%0d last=%b rdy=%b want 0 0000 0 0 1",
                     b0.oVld, b0.oDat, b0.oAddr, b0.oLast, b0.oRdy);
        end
        #1;
        rst_n = 1'b1;
        b0.iVld = 1'b1; b0.iDat = WORD_B; b0.iLen = 2'd3;
        cycle();
        b0.iVld = 1'b0;
        tests++;
        if ({b0.oVld, b0.oDat, b0.oAddr, b0.oLast} !== {1'b1, 16'h5555, 2'd0, 1'b0}) begin
            fails++;
            $display("[TB] FAIL mid_restart got vld=%b dat=%h addr=%0d last=%b want 1 5555 0 0",
                     b0.oVld, b0.oDat, b0.oAddr, b0.oLast);
        end
        cycle();
        tests++;
        if ({b0.oDat, b0.oAddr} !== {16'h6666, 2'd1}) begin
            fails++;
            $display("[TB] FAIL mid_second got dat=%h addr=%0d want 6666 1", b0.oDat, b0.oAddr);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_len();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
